spi_command_receiver: RTL and testbench
=======================================

// Module: spi_command_receiver
// PURPOSE
//   SPI slave front end upstream of the sequencer register file: turns pad-level sclk/mosi/ss_n
//   into single-cycle register write/read strobes in the clock domain.
//   Drives miso for readback. Sits between the pad-input mux (LA or io_in_reg) and the sequencer core.
// PARAMETERS
//   ADDR_W     7   register address width (frame bits 22:16)
//   DATA_W     16  register data width (frame bits 15:0)
//   SYNC_DEPTH 2   flops in each input synchronizer (>=2)
// PORTS
//   clock       in   1       system clock; all logic on posedge
//   reset_n     in   1       asynchronous, active-low reset
//   sclk        in   1       SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clock
//   mosi        in   1       SPI data in, MSB first
//   ss_n        in   1       SPI select, active low
//   miso        out  1       SPI data out
//   wr_en       out  1       one-cycle write strobe
//   wr_addr     out  ADDR_W  write address, valid with wr_en
//   wr_data     out  DATA_W  write data, valid with wr_en
//   rd_en       out  1       one-cycle read request
//   rd_addr     out  ADDR_W  read address, valid with rd_en
//   rd_data     in   DATA_W  read data, sampled exactly 1 cycle after rd_en
//   busy        out  1       high while a frame is in progress (state != IDLE)
//   frame_error out  1       one-cycle pulse when a frame aborts short
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; bit counter 0; synchronizer flops preset (ss_n sync to 1, others 0).
// - Inputs pass SYNC_DEPTH-flop synchronizers plus 1 edge-detect flop.
//   Pin-to-detect latency = SYNC_DEPTH+1 cycles.
//   Requires clock >= 8x sclk.
// - Frame = 24 bits: bit23 RW (1=read), bits22:16 addr, bits15:0 data.
//   mosi is sampled on the detected sclk rise.
// - FSM:
//   IDLE -> CMD on detected ss_n fall; the bit counter clears.
//   CMD -> DATA after the 8th rise; the RW bit and addr are latched.
//   DATA -> DONE after the 24th rise.
//   DONE -> IDLE on ss_n rise.
//   ss_n rise in CMD or DATA -> IDLE plus a frame_error pulse; no wr_en is issued.
// - Write: wr_en pulses the cycle after the 24th rise is detected, exactly once per frame.
// - Read (RW=1): rd_en plus rd_addr pulse the cycle after the 8th rise is detected.
//   rd_data loads the tx shifter the next cycle.
//   miso = tx[15] from the load; the shifter shifts left on each detected sclk fall, until 16 bits are out.
//   Mosi data bits of a read frame are ignored; no wr_en.
// - Bits after the 24th (in DONE) are ignored until ss_n rises.
// - miso = 0 whenever state is IDLE or the frame is a write.
// - ss_n fall while not IDLE (glitch) is ignored.
// - An sclk edge coincident with a detected ss_n rise is discarded.
// - Reset mid-frame: immediate IDLE; the partial frame is dropped; no strobes.
// CONFIGURATION
//   SPI_READBACK_EN defined: read path as above.
//   SPI_READBACK_EN undefined:
//   - miso tied 0; rd_en held 0; rd_addr held 0; rd_data unused.
//   - Read frames are consumed silently: no strobes, no error.
// STRUCTURE
//   Package mms_spi_pkg:
//   - FRAME_W=24, CMD_W=8, RW_BIT=23.
//   - State encoding localparams IDLE/CMD/DATA/DONE.
//   Sub-module spi_sync_edge (one per input): synchronizer plus rise/fall pulse outputs.
//   Instantiated for sclk, mosi (level only), ss_n.
// TESTING
// 1. Write frame 0x05_A5C3 (addr 0x05), clock 8x sclk.
//    -> single wr_en, wr_addr=0x05, wr_data=0xA5C3; busy drops after ss_n rise.
// 2. Read frame 0x85_xxxx, rd_data=0x1234 returned 1 cycle after rd_en.
//    -> rd_addr=0x05; miso bits MSB-first on sclk = 0x1234; no wr_en.
// 3. ss_n rises after 13 bits of a write.
//    -> frame_error 1-cycle pulse, no wr_en, state IDLE; next full frame is accepted normally.
// 4. 32 sclk pulses in one ss_n window, write addr 0x7F data 0xFFFF.
//    -> exactly one wr_en (0x7F, 0xFFFF); trailing 8 bits ignored.
// 5. reset_n asserted mid-DATA.
//    -> all outputs 0 immediately; no wr_en after release.
//    A frame started after release writes correctly.
// 6. Build without SPI_READBACK_EN, send read frame.
//    -> miso constant 0, rd_en never high, no frame_error.

Source files
------------

// File: rtl/mms_spi_pkg.sv
// rtl/mms_spi_pkg.sv - frame layout constants and FSM encoding for the SPI command receiver
package mms_spi_pkg;

  localparam int FRAME_W = 24;
  localparam int CMD_W   = 8;
  localparam int RW_BIT  = 23;
  localparam int CNT_W   = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_CMD  = CMD,
    S_DATA = DATA,
    S_DONE = DONE
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - pad input synchronizer with rise/fall pulses one flop after the level
module spi_sync_edge #(
  parameter int   SYNC_DEPTH = 2,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_prev;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= {SYNC_DEPTH{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_din};
      r_prev <= r_sync[SYNC_DEPTH-1];
    end
  end

  assign o_level = r_sync[SYNC_DEPTH-1];
  assign o_rise  = r_sync[SYNC_DEPTH-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_DEPTH-1] & r_prev;

endmodule

// File: rtl/spi_command_receiver.sv
// rtl/spi_command_receiver.sv - SPI mode-0 slave turning 24-bit frames into register strobes
// Readback path (rd_en/rd_addr/miso) is built only when SPI_READBACK_EN is defined.
module spi_command_receiver
  import mms_spi_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int SYNC_DEPTH = 2
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_sclk,
  input  logic              i_mosi,
  input  logic              i_ss_n,
  output logic              o_miso,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_frame_error
);

  localparam int               RW_IDX    = RW_BIT - (FRAME_W - CMD_W);
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FIRST_DAT = CNT_W'(CMD_W);

  logic w_sclk_rise, w_sclk_fall, w_mosi, w_ss_rise, w_ss_fall;
  logic w_sclk_unused_lvl, w_ss_unused_lvl, w_mosi_unused_rise, w_mosi_unused_fall;

  spi_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_din(i_sclk),
    .o_level(w_sclk_unused_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_din(i_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_unused_rise), .o_fall(w_mosi_unused_fall)
  );

  spi_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH), .RESET_VAL(1'b1)) u_sync_ss (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_din(i_ss_n),
    .o_level(w_ss_unused_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-2:0] r_shift;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en, r_frame_error;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [CMD_W-1:0]  w_cmd;
  logic              w_start, w_take_bit, w_cmd_done, w_frame_done, w_abort;

  assign w_cmd = {r_shift[CMD_W-2:0], w_mosi};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // A detected ss_n rise wins over any sclk edge in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_take_bit   = 1'b0;
    w_cmd_done   = 1'b0;
    w_frame_done = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = S_CMD;
          w_start     = 1'b1;
        end
      end
      S_CMD: begin
        if (w_ss_rise) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (w_sclk_rise) begin
          w_take_bit = 1'b1;
          if (r_bit_cnt == LAST_CMD) begin
            w_state_nxt = S_DATA;
            w_cmd_done  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_ss_rise) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (w_sclk_rise) begin
          w_take_bit = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt  = S_DONE;
            w_frame_done = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (w_ss_rise) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_error <= 1'b0;
    end else begin
      r_wr_en       <= 1'b0;
      r_frame_error <= w_abort;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_rw      <= 1'b0;
      end else if (w_take_bit) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shift   <= {r_shift[DATA_W-3:0], w_mosi};
      end
      if (w_cmd_done) begin
        r_rw   <= w_cmd[RW_IDX];
        r_addr <= w_cmd[ADDR_W-1:0];
      end
      if (w_frame_done && !r_rw) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr;
        r_wr_data <= {r_shift, w_mosi};
      end
    end
  end

  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_frame_error = r_frame_error;
  assign o_busy        = (r_state != S_IDLE);

`ifdef SPI_READBACK_EN
  logic              r_rd_en, r_rd_pend;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_tx;
  logic              w_rd_req, w_tx_shift;

  assign w_rd_req = w_cmd_done & w_cmd[RW_IDX];
  // The first data bit is presented from the load; shifting starts only after the master has sampled it.
  assign w_tx_shift = (r_state == S_DATA) && r_rw && w_sclk_fall && (r_bit_cnt > FIRST_DAT);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_en   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_addr <= '0;
      r_tx      <= '0;
    end else begin
      r_rd_en   <= w_rd_req;
      r_rd_pend <= r_rd_en;
      if (w_rd_req) r_rd_addr <= w_cmd[ADDR_W-1:0];
      if (w_start)         r_tx <= '0;
      else if (r_rd_pend)  r_tx <= i_rd_data;
      else if (w_tx_shift) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_miso    = o_busy & r_rw & r_tx[DATA_W-1];
`else
  logic w_unused_rb;
  assign w_unused_rb = ^{i_rd_data, w_sclk_fall};
  assign o_rd_en     = 1'b0;
  assign o_rd_addr   = '0;
  assign o_miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_command_receiver.sv
// tb/tb_spi_command_receiver.sv - directed self-checking bench for spi_command_receiver
module tb_spi_command_receiver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic        miso;
  logic        wr_en, rd_en, busy, frame_error;
  logic [6:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data = 16'hDEAD;
  logic [15:0] rd_value = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;

  int          wr_cnt = 0, rd_cnt = 0, err_cyc = 0, miso_cyc = 0;
  logic [6:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [15:0] last_wr_data = '0;
  int          s_wr, s_rd, s_err, s_miso;
  logic [15:0] miso_word;

  always #5 clk = ~clk;

  spi_command_receiver dut (
    .i_clock(clk), .i_reset_n(reset_n), .i_sclk(sclk), .i_mosi(mosi), .i_ss_n(ss_n),
    .o_miso(miso), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_busy(busy), .o_frame_error(frame_error)
  );

  // Register-file model: data is valid only in the cycle following rd_en.
  always @(posedge clk) rd_data <= rd_en ? rd_value : 16'hDEAD;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= wr_addr;
      last_wr_data <= wr_data;
    end
    if (rd_en) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= rd_addr;
    end
    if (frame_error) err_cyc  <= err_cyc + 1;
    if (miso)        miso_cyc <= miso_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_wr = wr_cnt; s_rd = rd_cnt; s_err = err_cyc; s_miso = miso_cyc;
  endtask

  task automatic start_frame();
    @(negedge clk);
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Sends n bits MSB first with sclk = clk/8; miso is captured just before each rise for frame bits 8..23.
  task automatic shift_bits(input logic [31:0] v, input int n);
    miso_word = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (4) @(negedge clk);
      if ((n - 1 - i) >= 8 && (n - 1 - i) < 24) miso_word = {miso_word[14:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic write_frame_check(input string tag, input logic [6:0] a, input logic [15:0] d);
    snap();
    start_frame();
    shift_bits({8'h00, 1'b0, a, d}, 24);
    end_frame();
    check({tag, "_wr_count"}, wr_cnt - s_wr, 1);
    check({tag, "_wr_addr"}, last_wr_addr, a);
    check({tag, "_wr_data"}, last_wr_data, d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_miso", miso, 0);
    check("rst_frame_error", frame_error, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain write frame 0x05_A5C3
    snap();
    start_frame();
    shift_bits(32'h0005A5C3, 24);
    check("t1_busy_in_frame", busy, 1);
    end_frame();
    check("t1_busy_after", busy, 0);
    check("t1_wr_count", wr_cnt - s_wr, 1);
    check("t1_wr_addr", last_wr_addr, 7'h05);
    check("t1_wr_data", last_wr_data, 16'hA5C3);
    check("t1_no_error", err_cyc - s_err, 0);

    // Abort after 13 bits, then a clean frame
    snap();
    start_frame();
    shift_bits(32'h0005A5C3 >> 11, 13);
    end_frame();
    check("t3_error_pulse_cycles", err_cyc - s_err, 1);
    check("t3_no_wr", wr_cnt - s_wr, 0);
    check("t3_busy", busy, 0);
    write_frame_check("t3_next", 7'h12, 16'hBEEF);

    // 32 clocks in one select window: trailing byte ignored
    snap();
    start_frame();
    shift_bits(32'h7FFFFFA5, 32);
    end_frame();
    check("t4_wr_count", wr_cnt - s_wr, 1);
    check("t4_wr_addr", last_wr_addr, 7'h7F);
    check("t4_wr_data", last_wr_data, 16'hFFFF);
    check("t4_no_error", err_cyc - s_err, 0);

    // Reset in the middle of the data phase
    snap();
    start_frame();
    shift_bits(32'h00334444 >> 8, 16);
    check("t5_busy_mid", busy, 1);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_wr_en", wr_en, 0);
    check("t5_rst_frame_error", frame_error, 0);
    check("t5_rst_miso", miso, 0);
    ss_n = 1'b1;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_wr_after", wr_cnt - s_wr, 0);
    check("t5_no_error_after", err_cyc - s_err, 0);
    write_frame_check("t5_next", 7'h2A, 16'h0F0F);

`ifdef SPI_READBACK_EN
    // Read frame addr 0x05 returning 0x1234; mosi data bits are don't-care
    rd_value = 16'h1234;
    snap();
    start_frame();
    shift_bits(32'h0085FFFF, 24);
    end_frame();
    check("t2_rd_count", rd_cnt - s_rd, 1);
    check("t2_rd_addr", last_rd_addr, 7'h05);
    check("t2_miso_word", miso_word, 16'h1234);
    check("t2_no_wr", wr_cnt - s_wr, 0);
    check("t2_no_error", err_cyc - s_err, 0);
    check("t2_miso_idle", miso, 0);
`else
    // Read frame is swallowed without strobes when readback is not built
    rd_value = 16'hFFFF;
    snap();
    start_frame();
    shift_bits(32'h00851234, 24);
    end_frame();
    check("t6_rd_count", rd_cnt - s_rd, 0);
    check("t6_miso_cycles", miso_cyc - s_miso, 0);
    check("t6_no_error", err_cyc - s_err, 0);
    check("t6_no_wr", wr_cnt - s_wr, 0);
    check("t6_busy", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
